sha256_multiround: RTL
======================

SHA256_MULTIROUND -- requirements
Module: sha256_multiround

Interface
REQ-001 SHALL have parameter UNROLL, default 4, meaning rounds per compute cycle; legal values 1, 2, 4, 8, 16; any other value SHALL fail elaboration.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin one 512-bit block compression.
- cont  in  1  sampled with start; 1 = chain from internal digest, ignore state_in.
- rdy  in  1  bus has data valid for addr.
- data  in  32  message word.
- addr  out  4  message word index 0..15.
- rq  out  1  word request.
- state_in  in  256  initial hash value {H0..H7}, H0 in [255:224].
- state_out  out  256  digest {H0..H7}.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- abort  in  1  present only with SHA256_ABORT_EN.
REQ-003 SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-004 SHALL implement FSM IDLE -> LOAD -> COMPUTE -> FINAL -> IDLE.
REQ-005 IDLE: start=1 SHALL load working vars a..h and H0..H7 from state_in if cont=0, or a..h from current H0..H7 if cont=1, and enter LOAD; start SHALL be ignored outside IDLE.
REQ-006 LOAD: rq SHALL be 1 and addr SHALL equal the word index, 0 at entry; each edge with rq&&rdy SHALL store data into W[addr] and increment the index; rdy low SHALL stall without loss.
REQ-007 On the capture of word 15, SHALL enter COMPUTE; rq SHALL be 0 and addr SHALL be 0 in every state other than LOAD.
REQ-008 COMPUTE SHALL last exactly 64/UNROLL cycles; each cycle SHALL apply UNROLL consecutive FIPS 180-4 rounds, using K[t] and W[t] for t = cycle*UNROLL .. +UNROLL-1.
REQ-009 W SHALL be a 16-entry circular schedule buffer; for t>=16, W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]; words generated in the same cycle SHALL chain combinationally; buffer pointer SHALL wrap modulo 16.
REQ-010 All additions SHALL be modulo 2^32.
REQ-011 FINAL: Hn <= Hn + working var for n = 0..7; done SHALL be 1 for exactly the following cycle, with the new digest on state_out; state SHALL return to IDLE.
REQ-012 Latency with rdy held 1: done high 18 + 64/UNROLL cycles after the start-sampling edge, e.g. 34 cycles for UNROLL=4.
REQ-013 state_out SHALL hold the last digest unchanged until the next FINAL.
REQ-014 start asserted in the cycle done is high SHALL be accepted, since the FSM is in IDLE; back-to-back blocks with cont=1 SHALL give a correct multi-block digest.

Reset
REQ-015 Reset SHALL force state=IDLE, done=0, busy=0, rq=0, addr=0, index=0, pointer=0; H, W and a..h SHALL NOT be reset.
REQ-016 Reset mid-operation SHALL abandon the block; no done pulse SHALL be produced, and state_out is undefined until the next completed block.

Configuration
REQ-017 Macro SHA256_ABORT_EN defined: port abort exists; abort=1 in LOAD or COMPUTE SHALL return to IDLE at the next edge, with no done and H0..H7 unchanged; abort in FINAL or IDLE SHALL be ignored.
REQ-018 Macro undefined: no abort port and no abort logic; behaviour otherwise identical.

Structure
REQ-019 Package sha256_pkg SHALL hold the K[0..63] table, the IV constant, FSM state encoding, and functions S0, S1, s0, s1, ch, maj.
REQ-020 Sub-module sha256_round SHALL be one combinational round, (a..h, K, W) -> (a..h), instantiated UNROLL times by generate.

Verification
REQ-021 Reset, UNROLL=4, state_in=IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, block "abc" (61626380, 14x 00000000, 00000018), rdy=1 -> state_out ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; done exactly 34 cycles after start.
REQ-022 Same "abc" case for UNROLL=1, 2, 8, 16 -> identical digest; done latency 82, 50, 26, 22 cycles.
REQ-023 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmnomnopq": block 2 started with cont=1 in the done cycle -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-024 "abc" with rdy toggling pseudo-randomly -> same digest; each word captured exactly once; addr sequence 0..15.
REQ-025 rst_n low during COMPUTE, then a new "abc" start -> no spurious done; correct digest.
REQ-026 With SHA256_ABORT_EN, abort at LOAD word 7 -> IDLE next cycle, no done, state_out unchanged; start in IDLE -> normal completion.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state encoding and the FIPS 180-4 round/schedule
// functions shared by sha256_multiround and sha256_round.
package sha256_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_FINAL   = 2'd3
   } state_t;

   localparam logic [255:0] IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   localparam logic [0:63][31:0] K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] S0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] S1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; working vars packed {a..h},
// with a in [255:224].
module sha256_round
   import sha256_pkg::*;
(
   input  logic [255:0] i_vars,
   input  logic [31:0]  i_k,
   input  logic [31:0]  i_w,
   output logic [255:0] o_vars
);

   logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
   logic [31:0] w_t1, w_t2;

   assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_vars;

   assign w_t1   = w_h + S1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
   assign w_t2   = S0(w_a) + maj(w_a, w_b, w_c);
   assign o_vars = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

// File: rtl/sha256_multiround.sv
// SHA-256 single-block compressor, UNROLL rounds per cycle. Optional abort
// input is built when SHA256_ABORT_EN is defined.
module sha256_multiround
   import sha256_pkg::*;
#(
   parameter int UNROLL = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         cont,
   input  logic         rdy,
   input  logic [31:0]  data,
   output logic [3:0]   addr,
   output logic         rq,
   input  logic [255:0] state_in,
   output logic [255:0] state_out,
   output logic         busy,
   output logic         done
`ifdef SHA256_ABORT_EN
   ,
   input  logic         abort
`endif
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
      $error("sha256_multiround: UNROLL must be 1, 2, 4, 8 or 16");
   end

   localparam logic [5:0] STEP     = 6'(UNROLL);
   localparam logic [5:0] LAST_RND = 6'(64 - UNROLL);

   state_t       r_state;
   logic [3:0]   r_idx;
   logic [5:0]   r_rnd;
   logic         r_rq, r_busy, r_done;
   logic [255:0] r_h, r_v;
   logic [31:0]  r_w [16];

   logic [31:0]  w_buf [16];
   logic [31:0]  w_rw [UNROLL];
   logic [255:0] w_vars [UNROLL+1];
   logic [3:0]   w_ptr, w_idx;
   logic         w_sched, w_abort;

`ifdef SHA256_ABORT_EN
   assign w_abort = abort && (r_state == ST_LOAD || r_state == ST_COMPUTE);
`else
   assign w_abort = 1'b0;
`endif

   // Handshake: a word moves on every rising edge where rq && rdy; rq stays
   // high and addr holds the word index through any number of rdy-low stalls.
   assign rq        = r_rq;
   assign addr      = r_idx;
   assign busy      = r_busy;
   assign done      = r_done;
   assign state_out = r_h;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= 4'd0;
         r_rnd   <= 6'd0;
         r_rq    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_abort) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_rnd   <= 6'd0;
            r_rq    <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: if (start) begin
                  r_state <= ST_LOAD;
                  r_rq    <= 1'b1;
                  r_busy  <= 1'b1;
               end
               ST_LOAD: if (rdy) begin
                  r_idx <= r_idx + 4'd1;
                  if (r_idx == 4'd15) begin
                     r_state <= ST_COMPUTE;
                     r_rq    <= 1'b0;
                  end
               end
               ST_COMPUTE: begin
                  r_rnd <= r_rnd + STEP;
                  if (r_rnd == LAST_RND) r_state <= ST_FINAL;
               end
               ST_FINAL: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   // Schedule words of one cycle chain through w_buf; slot t mod 16 holds W[t-16].
   assign w_ptr   = r_rnd[3:0];
   assign w_sched = |r_rnd[5:4];

   always_comb begin
      w_idx = 4'd0;
      w_buf = r_w;
      for (int j = 0; j < UNROLL; j++) begin
         w_idx = w_ptr + 4'(j);
         if (w_sched)
            w_buf[w_idx] = s1(w_buf[w_idx - 4'd2]) + w_buf[w_idx - 4'd7]
                         + s0(w_buf[w_idx - 4'd15]) + w_buf[w_idx];
         w_rw[j] = w_buf[w_idx];
      end
   end

   assign w_vars[0] = r_v;

   for (genvar g = 0; g < UNROLL; g++) begin : g_round
      sha256_round u_round (
         .i_vars (w_vars[g]),
         .i_k    (K[6'(r_rnd + 6'(g))]),
         .i_w    (w_rw[g]),
         .o_vars (w_vars[g+1])
      );
   end

   always_ff @(posedge clk) begin
      case (r_state)
         ST_IDLE: if (start) begin
            if (cont) begin
               r_v <= r_h;
            end else begin
               r_v <= state_in;
               r_h <= state_in;
            end
         end
         ST_LOAD: if (rdy) r_w[r_idx] <= data;
         ST_COMPUTE: begin
            r_v <= w_vars[UNROLL];
            r_w <= w_buf;
         end
         ST_FINAL: begin
            for (int n = 0; n < 8; n++)
               r_h[32*n +: 32] <= r_h[32*n +: 32] + r_v[32*n +: 32];
         end
         default: ;
      endcase
   end

endmodule
